// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REGF = 2'b00;
    localparam logic [1:0] FWD_EXM  = 2'b01;
    localparam logic [1:0] FWD_MWB  = 2'b10;

    typedef enum logic [0:0] {
        CTRL_RUN      = 1'b0,
        CTRL_MEM_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register snapshot in, per-stage stall/flush and forwarding selects out.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = `REG_ADDR_W,
    parameter int CNT_W      = 32
);
    logic                  en;
    logic                  id_use_r1;
    logic                  id_use_r2;
    logic [REG_ADDR_W-1:0] id_addr_r1;
    logic [REG_ADDR_W-1:0] id_addr_r2;
    logic                  idex_reg_wr;
    logic                  idex_is_load;
    logic                  idex_flush;
    logic [REG_ADDR_W-1:0] idex_addr_rd;
    logic                  exm_reg_wr;
    logic                  exm_flush;
    logic [REG_ADDR_W-1:0] exm_addr_rd;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ack;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush_if;
    logic                  flush_id;
    logic [1:0]            fwd_r1;
    logic [1:0]            fwd_r2;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output en, id_use_r1, id_use_r2, id_addr_r1, id_addr_r2,
               idex_reg_wr, idex_is_load, idex_flush, idex_addr_rd,
               exm_reg_wr, exm_flush, exm_addr_rd, branch_taken, mem_req, mem_ack,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id,
               fwd_r1, fwd_r2, mem_err, stall_cycles
    );

    modport slave (
        input  en, id_use_r1, id_use_r2, id_addr_r1, id_addr_r2,
               idex_reg_wr, idex_is_load, idex_flush, idex_addr_rd,
               exm_reg_wr, exm_flush, exm_addr_rd, branch_taken, mem_req, mem_ack,
        output stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id,
               fwd_r1, fwd_r2, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Hit detection and forwarding priority for one ID source operand (purely combinational).
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = `REG_ADDR_W
) (
    input  logic                  use_src,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  idex_reg_wr,
    input  logic                  idex_flush,
    input  logic [REG_ADDR_W-1:0] idex_addr_rd,
    input  logic                  exm_reg_wr,
    input  logic                  exm_flush,
    input  logic [REG_ADDR_W-1:0] exm_addr_rd,
    output logic                  idex_hit,
    output logic [1:0]            fwd
);
    logic exm_hit;

    // r0 is hardwired zero, so it never takes a forwarded value
    always_comb begin
        idex_hit = use_src && (addr != '0) && idex_reg_wr && !idex_flush && (idex_addr_rd == addr);
        exm_hit  = use_src && (addr != '0) && exm_reg_wr && !exm_flush && (exm_addr_rd == addr);
        fwd      = idex_hit ? FWD_EXM : (exm_hit ? FWD_MWB : FWD_REGF);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush generation with registered EX forwarding selects and a memory-wait FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = `REG_ADDR_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic             mem_err_q;
    logic [1:0]       fwd_r1_q, fwd_r2_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic       hit_r1, hit_r2;
    logic [1:0] sel_r1, sel_r2;
    logic       load_use, mem_stall, timeout;
    logic       stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id;

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_r1 (
        .use_src(bus.id_use_r1), .addr(bus.id_addr_r1),
        .idex_reg_wr(bus.idex_reg_wr), .idex_flush(bus.idex_flush), .idex_addr_rd(bus.idex_addr_rd),
        .exm_reg_wr(bus.exm_reg_wr), .exm_flush(bus.exm_flush), .exm_addr_rd(bus.exm_addr_rd),
        .idex_hit(hit_r1), .fwd(sel_r1)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_r2 (
        .use_src(bus.id_use_r2), .addr(bus.id_addr_r2),
        .idex_reg_wr(bus.idex_reg_wr), .idex_flush(bus.idex_flush), .idex_addr_rd(bus.idex_addr_rd),
        .exm_reg_wr(bus.exm_reg_wr), .exm_flush(bus.exm_flush), .exm_addr_rd(bus.exm_addr_rd),
        .idex_hit(hit_r2), .fwd(sel_r2)
    );

    assign load_use  = (hit_r1 || hit_r2) && bus.idex_is_load;
    assign mem_stall = (state_q == CTRL_RUN) ? (bus.mem_req && !bus.mem_ack) : !bus.mem_ack;
    assign timeout   = (state_q == CTRL_MEM_WAIT) && !bus.mem_ack && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CTRL_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            case (state_q)
                CTRL_RUN:      if (bus.mem_req && !bus.mem_ack) state_d = CTRL_MEM_WAIT;
                CTRL_MEM_WAIT: if (bus.mem_ack || timeout)      state_d = CTRL_RUN;
                default:       state_d = CTRL_RUN;
            endcase
        end
    end

    // Memory waits outrank redirects: EX holds the branch stable until the access completes
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        if (rst) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            {flush_if, flush_id}                      = 2'b11;
        end else if (!bus.en || mem_stall) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else if (bus.branch_taken) begin
            {flush_if, flush_id} = 2'b11;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_id = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            fwd_r1_q    <= FWD_REGF;
            fwd_r2_q    <= FWD_REGF;
            stall_cnt_q <= '0;
        end else if (bus.en) begin
            if (state_q == CTRL_MEM_WAIT && state_d == CTRL_MEM_WAIT) wait_q <= wait_q + 1'b1;
            else                                                      wait_q <= '0;
            if (timeout) mem_err_q <= 1'b1;
            if (!mem_stall) begin
                fwd_r1_q <= flush_id ? FWD_REGF : sel_r1;
                fwd_r2_q <= flush_id ? FWD_REGF : sel_r2;
            end
            if (stall_if) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.stall_if     = stall_if;
    assign bus.stall_id     = stall_id;
    assign bus.stall_ex     = stall_ex;
    assign bus.stall_mem    = stall_mem;
    assign bus.flush_if     = flush_if;
    assign bus.flush_id     = flush_id;
    assign bus.fwd_r1       = fwd_r1_q;
    assign bus.fwd_r2       = fwd_r2_q;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench: each cycle's stimulus pushes its expected outputs; a negedge monitor pops and compares.
// Latency: fwd is checked one cycle after the stimulus; stall/flush are checked in the same cycle.
// Backpressure: none; a memory wait stalls every stage until ack or timeout.
module tb_hazard_ctrl;
    localparam int AW = `REG_ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(32)) hif();

    hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(hif)
    );

    typedef struct {
        string       tag;
        logic [10:0] vec;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic want(string tag, logic [3:0] stl, logic [1:0] fl, logic [1:0] f1,
                        logic [1:0] f2, logic err, int cnt);
        exp_t e;
        e.tag = tag;
        e.vec = {stl, fl, f1, f2, err};
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic check_now(string tag, logic act, logic exp_val);
        checks++;
        if (act !== exp_val) begin
            failures++;
            $display("FAIL %s: got %b, want %b", tag, act, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.en           = 1'b1;
        hif.id_use_r1    = 1'b0;
        hif.id_use_r2    = 1'b0;
        hif.id_addr_r1   = '0;
        hif.id_addr_r2   = '0;
        hif.idex_reg_wr  = 1'b0;
        hif.idex_is_load = 1'b0;
        hif.idex_flush   = 1'b0;
        hif.idex_addr_rd = '0;
        hif.exm_reg_wr   = 1'b0;
        hif.exm_flush    = 1'b0;
        hif.exm_addr_rd  = '0;
        hif.branch_taken = 1'b0;
        hif.mem_req      = 1'b0;
        hif.mem_ack      = 1'b0;
    endtask

    task automatic src(logic u1, int a1, logic u2, int a2);
        hif.id_use_r1  = u1;
        hif.id_addr_r1 = AW'(a1);
        hif.id_use_r2  = u2;
        hif.id_addr_r2 = AW'(a2);
    endtask

    task automatic idex(logic wr, logic ld, int rd);
        hif.idex_reg_wr  = wr;
        hif.idex_is_load = ld;
        hif.idex_addr_rd = AW'(rd);
    endtask

    task automatic exm(logic wr, int rd);
        hif.exm_reg_wr  = wr;
        hif.exm_addr_rd = AW'(rd);
    endtask

    initial begin
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {hif.stall_if, hif.stall_id, hif.stall_ex, hif.stall_mem,
                       hif.flush_if, hif.flush_id, hif.fwd_r1, hif.fwd_r2, hif.mem_err};
                checks++;
                if (act !== e.vec || hif.stall_cycles !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got stl/fl/f1/f2/err=%b cnt=%0d, want %b cnt=%0d",
                             e.tag, act, hif.stall_cycles, e.vec, e.cnt);
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); want("reset_state", 4'hF, 2'b11, 2'd0, 2'd0, 1'b0, 0);
        check_now("reset_stall_if", hif.stall_if, 1'b1);
        check_now("reset_flush_id", hif.flush_id, 1'b1);
        check_now("reset_mem_err", hif.mem_err, 1'b0);
        tick(); rst = 1'b0; idle(); want("idle_after_reset", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 0);

        // forwarding from ID/EX, then EX/MEM, then both (younger wins), then flushed producers
        tick(); idle(); src(1, 3, 0, 0); idex(1, 0, 3);
        want("fwd_idex_issue", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 0);
        tick(); idle(); src(1, 3, 0, 0); exm(1, 3);
        want("fwd_r1_exm", 4'h0, 2'b00, 2'd1, 2'd0, 1'b0, 0);
        tick(); idle(); src(1, 3, 1, 3); idex(1, 0, 3); exm(1, 3);
        want("fwd_r1_mwb", 4'h0, 2'b00, 2'd2, 2'd0, 1'b0, 0);
        tick(); idle(); src(1, 3, 1, 4); idex(1, 0, 3); hif.idex_flush = 1'b1; exm(1, 4); hif.exm_flush = 1'b1;
        want("fwd_younger_wins", 4'h0, 2'b00, 2'd1, 2'd1, 1'b0, 0);

        // load-use bubble, then forward from MEM/WB; load to r0 is not a hazard
        tick(); idle(); src(0, 0, 1, 5); idex(1, 1, 5);
        want("load_use_stall", 4'b1100, 2'b01, 2'd0, 2'd0, 1'b0, 0);
        tick(); idle(); src(0, 0, 1, 5); exm(1, 5);
        want("load_bubble_fwd0", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 1);
        tick(); idle(); src(1, 0, 0, 0); idex(1, 1, 0);
        want("load_fwd_mwb", 4'h0, 2'b00, 2'd0, 2'd2, 1'b0, 1);

        // branch beats simultaneous load-use and clears forwarding
        tick(); idle(); src(1, 5, 1, 5); idex(1, 1, 5); hif.branch_taken = 1'b1;
        want("r0_no_hazard_branch", 4'h0, 2'b11, 2'd0, 2'd0, 1'b0, 1);
        tick(); idle(); src(1, 3, 0, 0); idex(1, 0, 3);
        want("branch_fwd_clear", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 1);

        // memory wait with ack on the fifth cycle; branch and fwd update ignored while stalled
        tick(); idle(); hif.mem_req = 1'b1; hif.branch_taken = 1'b1; src(0, 0, 1, 7); exm(1, 7);
        want("mem_req_stall", 4'hF, 2'b00, 2'd1, 2'd0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); hif.mem_req = 1'b1; hif.branch_taken = 1'b1; src(0, 0, 1, 7); exm(1, 7);
            want("mem_wait_stall", 4'hF, 2'b00, 2'd1, 2'd0, 1'b0, 2 + i);
        end
        tick(); idle(); hif.mem_req = 1'b1; hif.mem_ack = 1'b1;
        want("mem_ack_release", 4'h0, 2'b00, 2'd1, 2'd0, 1'b0, 5);
        tick(); idle(); src(0, 0, 1, 9); idex(1, 0, 9);
        want("mem_back_in_run", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 5);

        // core disable holds fwd and the stall counter
        tick(); idle(); hif.en = 1'b0; src(1, 5, 0, 0); idex(1, 1, 5);
        want("en_low_hold", 4'hF, 2'b00, 2'd0, 2'd1, 1'b0, 5);
        tick(); idle();
        want("en_high_resume", 4'h0, 2'b00, 2'd0, 2'd1, 1'b0, 5);

        // timeout: one RUN stall cycle plus eight MEM_WAIT cycles, then sticky error
        tick(); idle(); hif.mem_req = 1'b1;
        want("timeout_req", 4'hF, 2'b00, 2'd0, 2'd0, 1'b0, 5);
        for (int i = 0; i < 8; i++) begin
            tick(); idle();
            want("timeout_wait", 4'hF, 2'b00, 2'd0, 2'd0, 1'b0, 6 + i);
        end
        tick(); idle();
        want("timeout_err_set", 4'h0, 2'b00, 2'd0, 2'd0, 1'b1, 14);
        check_now("timeout_mem_err", hif.mem_err, 1'b1);
        check_now("timeout_stall_released", hif.stall_if, 1'b0);
        tick(); idle(); src(1, 3, 0, 0); idex(1, 0, 3);
        want("mem_err_sticky", 4'h0, 2'b00, 2'd0, 2'd0, 1'b1, 14);

        // reset in the middle of a memory wait
        tick(); idle(); hif.mem_req = 1'b1;
        want("pre_rst_req", 4'hF, 2'b00, 2'd1, 2'd0, 1'b1, 14);
        tick(); idle(); hif.mem_req = 1'b1;
        want("pre_rst_wait", 4'hF, 2'b00, 2'd1, 2'd0, 1'b1, 15);
        tick(); idle(); hif.mem_req = 1'b1; rst = 1'b1;
        want("rst_mid_wait", 4'hF, 2'b11, 2'd0, 2'd0, 1'b0, 0);
        tick(); idle();
        want("rst_held", 4'hF, 2'b11, 2'd0, 2'd0, 1'b0, 0);
        tick(); rst = 1'b0; idle();
        want("rst_release_run", 4'h0, 2'b00, 2'd0, 2'd0, 1'b0, 0);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit for the core. Generates per-stage stall and flush controls and registered operand-forwarding selects for the EX stage. Covers load-use hazards, taken-branch redirect and multi-cycle memory waits. Sits beside the IF/ID/EX/MEM/WB stages and drives their stall/flush inputs.

Parameters:
REG_ADDR_W, `REG_ADDR_W, register address width
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  core enable
id_use_r1 / id_use_r2  in  1  ID instruction reads r1 / r2
id_addr_r1 / id_addr_r2  in  REG_ADDR_W  ID source addresses
idex_reg_wr / idex_is_load / idex_flush  in  1  ID/EX register contents
idex_addr_rd  in  REG_ADDR_W  ID/EX destination
exm_reg_wr / exm_flush  in  1  EX/MEM register contents
exm_addr_rd  in  REG_ADDR_W  EX/MEM destination
branch_taken  in  1  taken branch resolved in EX
mem_req / mem_ack  in  1  MEM access issued / completed
stall_if, stall_id, stall_ex, stall_mem  out  1  per-stage hold
flush_if, flush_id  out  1  turn IF/ID (resp. ID/EX) content into bubble
fwd_r1, fwd_r2  out  2  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  count of cycles with stall_if=1 and en=1

Behaviour:
- Reset (async, rst=1): state=RUN, fwd_r1=fwd_r2=00, mem_err=0, wait counter=0, stall_cycles=0. While rst=1, all stall_* and flush_* outputs are forced to 1.
- Hazard definitions (address 0 never matches):
  - idex_hit(x) = id_use_x & idex_reg_wr & !idex_flush & idex_addr_rd==id_addr_x
  - exm_hit(x) = id_use_x & exm_reg_wr & !exm_flush & exm_addr_rd==id_addr_x
  - load_use = (idex_hit(r1) | idex_hit(r2)) & idex_is_load
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req & !mem_ack.
  - MEM_WAIT -> RUN on mem_ack, or when the wait counter reaches MEM_TIMEOUT. The timeout case also sets mem_err=1, which stays set until reset.
  - The wait counter clears on RUN entry and increments each MEM_WAIT cycle.
- Outputs are combinational from state and inputs, evaluated in priority order:
  1. en=0: all stall_*=1, flush_*=0. State, counters and fwd registers hold.
  2. Memory stall (RUN with mem_req & !mem_ack, or MEM_WAIT with !mem_ack): all stall_*=1, flush_*=0. branch_taken and load_use are ignored. They are re-evaluated when EX releases, since EX holds its inputs stable.
  3. branch_taken: flush_if=1, flush_id=1, no stalls. Branch wins over a simultaneous load_use because the ID instruction is wrong-path.
  4. load_use: stall_if=1, stall_id=1, flush_id=1 (one bubble into EX); stall_ex=stall_mem=0. The following cycle the load is in EX/MEM, load_use is false, and the instruction advances with forwarding 10.
  5. Otherwise all outputs are 0.
- Forwarding registers (update on posedge clk only when en=1 and no memory stall):
  - If flush_id=1: fwd_r1=fwd_r2=00.
  - Else fwd_x <= idex_hit(x) ? 01 : exm_hit(x) ? 10 : 00. The younger producer wins.
  - The registered value is valid while the instruction occupies EX, i.e. aligned with the ID->EX transfer.
- Latency: flush/stall respond in the same cycle; fwd responds one cycle later (registered).
- stall_cycles increments by 1 per cycle with en=1 and stall_if=1, wraps modulo 2^CNT_W, and holds while en=0.

Decomposition:
- Shared package/defines: FWD_REGF=2'b00, FWD_EXM=2'b01, FWD_MWB=2'b10; FSM state encodings CTRL_RUN, CTRL_MEM_WAIT; `REG_ADDR_W.
- One natural sub-module, fwd_sel: combinational hit detection and priority for one operand, instantiated twice (r1, r2).

Test Plan:
- ADD r3 in ID/EX, ID reads r3 as r1 -> next cycle fwd_r1=01, fwd_r2=00, no stall. Same with r3 only in EX/MEM -> fwd_r1=10.
- Load to r5 in ID/EX, ID reads r5 as r2 -> 1 cycle with stall_if=stall_id=flush_id=1. Next cycle no stall, fwd_r2=10. Destination r0 -> no stall, fwd 00.
- branch_taken with load_use the same cycle -> flush_if=flush_id=1, stall_if=0, fwd_r1=fwd_r2=00 next cycle.
- mem_req=1, mem_ack low for 4 cycles -> all stall_*=1 for those cycles, state MEM_WAIT; ack in cycle 5 -> RUN, stalls drop, stall_cycles incremented by 4.
- MEM_TIMEOUT=8, mem_ack never asserted -> exit to RUN after 8 wait cycles, mem_err=1 and remains 1.
- Assert rst mid-MEM_WAIT -> immediately state=RUN, mem_err=0, stall_cycles=0, fwd 00, all stall/flush=1 while rst held.
